text_cursor_ctrl: RTL

- Write-side controller for the character text buffer (ROWS x COLS cells of DATA_WIDTH bits).
- Takes a byte stream from the UART receive path over a valid/ready handshake, interprets control codes, tracks the cursor, and drives the buffer's write port (we, w_row, w_col, din).
- Owns all buffer clearing: full clear after reset and on form feed, single-row clear on line advance. The buffer therefore never sees raw control codes.

---
 rtl/text_cursor_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/text_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// text_cursor_ctrl
//
// Write-side controller for a ROWS x COLS character text buffer. Accepts a
// character stream over a valid/ready handshake, interprets control codes,
// tracks the cursor and drives the buffer write port. All buffer clearing is
// generated here: a full clear after reset and on form feed, and a single-row
// clear whenever the cursor advances to a new line.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   upstream character valid
//   in_data   in   upstream character (control codes decoded on bits [7:0])
//   in_ready  out  high only when idle; transfer on in_valid && in_ready
//   we        out  buffer write enable (registered)
//   w_row     out  buffer write row (registered)
//   w_col     out  buffer write column (registered)
//   din       out  buffer write data (registered)
//   cur_row   out  cursor row
//   cur_col   out  cursor column
//   busy      out  high while a clear sequence runs (== !in_ready)
// -----------------------------------------------------------------------------
module text_cursor_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 4,
   parameter int COLS       = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     in_ready,
   output logic                     we,
   output logic [$clog2(ROWS)-1:0]  w_row,
   output logic [$clog2(COLS)-1:0]  w_col,
   output logic [DATA_WIDTH-1:0]    din,
   output logic [$clog2(ROWS)-1:0]  cur_row,
   output logic [$clog2(COLS)-1:0]  cur_col,
   output logic                     busy
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0]         COL_LAST = CW'(COLS - 1);
   localparam logic [DATA_WIDTH-1:0] SPACE    = DATA_WIDTH'(8'h20);

   localparam logic [7:0] C_BS = 8'h08;
   localparam logic [7:0] C_LF = 8'h0A;
   localparam logic [7:0] C_FF = 8'h0C;
   localparam logic [7:0] C_CR = 8'h0D;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLRROW = 2'd1,
      S_CLRALL = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [RW-1:0]          clr_row_q, clr_row_d;
   logic [CW-1:0]          clr_col_q, clr_col_d;
   logic [RW-1:0]          cur_row_q, cur_row_d;
   logic [CW-1:0]          cur_col_q, cur_col_d;
   logic                   we_q, we_d;
   logic [RW-1:0]          w_row_q, w_row_d;
   logic [CW-1:0]          w_col_q, w_col_d;
   logic [DATA_WIDTH-1:0]  din_q, din_d;

   logic [7:0]             code;
   logic                   line_adv;

   assign code = in_data[7:0];

   // -------------------------------------------------------------------------
   // State register. Reset lands in CLRALL so the buffer is wiped after every
   // reset, including one that interrupts a clear already in progress.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLRALL;
         clr_row_q <= '0;
         clr_col_q <= '0;
         cur_row_q <= '0;
         cur_col_q <= '0;
         we_q      <= 1'b0;
         w_row_q   <= '0;
         w_col_q   <= '0;
         din_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_row_q <= clr_row_d;
         clr_col_q <= clr_col_d;
         cur_row_q <= cur_row_d;
         cur_col_q <= cur_col_d;
         we_q      <= we_d;
         w_row_q   <= w_row_d;
         w_col_q   <= w_col_d;
         din_q     <= din_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state / write-port logic. The write address and data hold their
   // previous values when no write is issued; only we qualifies them.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_row_d = clr_row_q;
      clr_col_d = clr_col_q;
      cur_row_d = cur_row_q;
      cur_col_d = cur_col_q;
      we_d      = 1'b0;
      w_row_d   = w_row_q;
      w_col_d   = w_col_q;
      din_d     = din_q;
      line_adv  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (code >= 8'h20 && code <= 8'h7E) begin
                  we_d    = 1'b1;
                  w_row_d = cur_row_q;
                  w_col_d = cur_col_q;
                  din_d   = in_data;
                  if (cur_col_q != COL_LAST) begin
                     cur_col_d = cur_col_q + CW'(1);
                  end else begin
                     line_adv = 1'b1;
                  end
               end else begin
                  case (code)
                     C_LF: line_adv = 1'b1;
                     C_CR: cur_col_d = '0;
                     C_BS: begin
                        if (cur_col_q != '0) begin
                           cur_col_d = cur_col_q - CW'(1);
                           we_d      = 1'b1;
                           w_row_d   = cur_row_q;
                           w_col_d   = cur_col_q - CW'(1);
                           din_d     = SPACE;
                        end else if (cur_row_q != '0) begin
                           cur_row_d = cur_row_q - RW'(1);
                           cur_col_d = COL_LAST;
                           we_d      = 1'b1;
                           w_row_d   = cur_row_q - RW'(1);
                           w_col_d   = COL_LAST;
                           din_d     = SPACE;
                        end
                     end
                     C_FF: begin
                        cur_row_d = '0;
                        cur_col_d = '0;
                        clr_row_d = '0;
                        clr_col_d = '0;
                        state_d   = S_CLRALL;
                     end
                     default: ; // unsupported codes are consumed silently
                  endcase
               end

               // Rows wrap circularly; the newly entered row is blanked.
               if (line_adv) begin
                  cur_col_d = '0;
                  cur_row_d = cur_row_q + RW'(1);
                  clr_col_d = '0;
                  state_d   = S_CLRROW;
               end
            end
         end

         S_CLRROW: begin
            // cur_row already points at the new row when this state runs.
            we_d      = 1'b1;
            w_row_d   = cur_row_q;
            w_col_d   = clr_col_q;
            din_d     = SPACE;
            clr_col_d = clr_col_q + CW'(1);
            if (clr_col_q == COL_LAST) begin
               state_d = S_IDLE;
            end
         end

         S_CLRALL: begin
            we_d      = 1'b1;
            w_row_d   = clr_row_q;
            w_col_d   = clr_col_q;
            din_d     = SPACE;
            clr_col_d = clr_col_q + CW'(1);
            if (clr_col_q == COL_LAST) begin
               clr_row_d = clr_row_q + RW'(1);
               if (clr_row_q == ROW_LAST) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            clr_row_d = '0;
            clr_col_d = '0;
            state_d   = S_CLRALL;
         end
      endcase
   end

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign we       = we_q;
   assign w_row    = w_row_q;
   assign w_col    = w_col_q;
   assign din      = din_q;
   assign cur_row  = cur_row_q;
   assign cur_col  = cur_col_q;

endmodule
